aes_core_arbiter: RTL and testbench

Sequencing controller and two-requester round-robin arbiter that shares one combinational AES-128 core (128-bit plaintext, 128-bit key, mode flag, 128-bit result) between two clients. It registers the winning request onto the core inputs and holds them stable for a programmable settle window, treating the core as a multicycle path. It then captures the core result and returns it to the owning requester over a valid/ready response channel. It sits between the bus-side request masters and the shared AES datapath.

---
 rtl/aes_core_arbiter_if.sv | 22 ++
 rtl/aes_core_arbiter.sv | 112 +++++++++++
 tb/tb_aes_core_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_core_arbiter_if.sv
// Request/response bundle between the two bus-side clients and the AES core arbiter.
// Both requesters share one bundle: bit i (or slice [128*i +: 128]) belongs to requester i.
interface aes_core_arbiter_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_text;
    logic [255:0] req_key;
    logic [1:0]   req_mode;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_data;

    modport master (
        output req_valid, req_text, req_key, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_text, req_key, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that time-shares one combinational AES-128 core between two requesters.
// Define AES_ARB_STATS_EN to add the per-requester completed-operation counters stat_ops0/stat_ops1.
module aes_core_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    aes_core_arbiter_if.slave   bus,
    output logic [127:0]        core_text,
    output logic [127:0]        core_key,
    output logic                core_flag,
    input  logic [127:0]        core_result,
    output logic                busy
`ifdef AES_ARB_STATS_EN
    ,
    output logic [15:0]         stat_ops0,
    output logic [15:0]         stat_ops1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic         owner;
    logic         last_grant;
    logic [127:0] rsp_data_q;

    logic         grant_any;
    logic         grant_idx;
    logic         rsp_done;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        case (bus.req_valid)
            2'b01:   begin grant_any = 1'b1; grant_idx = 1'b0;        end
            2'b10:   begin grant_any = 1'b1; grant_idx = 1'b1;        end
            2'b11:   begin grant_any = 1'b1; grant_idx = ~last_grant; end
            default: ;
        endcase
    end

    // Ready is withheld while reset is asserted so no client sees a handshake that is dropped.
    assign bus.req_ready = (state == ST_IDLE && grant_any && !rst) ? (2'b01 << grant_idx) : 2'b00;
    assign bus.rsp_valid = (state == ST_RESP) ? (2'b01 << owner) : 2'b00;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != ST_IDLE);
    assign rsp_done      = (state == ST_RESP) && bus.rsp_ready[owner];

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            // NOTE: the wide datapath registers are reset too, because their reset value is observable.
            core_text  <= '0;
            core_key   <= '0;
            core_flag  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        core_text <= grant_idx ? bus.req_text[255:128] : bus.req_text[127:0];
                        core_key  <= grant_idx ? bus.req_key[255:128]  : bus.req_key[127:0];
                        core_flag <= bus.req_mode[grant_idx];
                        owner     <= grant_idx;
                        cnt       <= SETTLE_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Core inputs have been stable for the full settle window once cnt reaches zero.
                    if (cnt == 4'd0) begin
                        rsp_data_q <= core_result;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        last_grant <= owner;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AES_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
        end else if (rsp_done) begin
            if (owner) stat_ops1 <= stat_ops1 + 16'd1;
            else       stat_ops0 <= stat_ops0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: dut_a runs with a settle window of 2, dut_b with 1.
// Directed vectors and corner sequences, then randomized traffic against a transaction-level model.
module tb_aes_core_arbiter;

    localparam int SETTLE_A = 2;
    localparam int SETTLE_B = 1;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic         req;
        logic [127:0] text;
        logic [127:0] key;
        logic         mode;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Index 0 drives dut_a, index 1 drives dut_b.
    logic         rst[2];
    logic [1:0]   req_valid[2];
    logic [1:0]   req_ready[2];
    logic [255:0] req_text[2];
    logic [255:0] req_key[2];
    logic [1:0]   req_mode[2];
    logic [1:0]   rsp_valid[2];
    logic [1:0]   rsp_ready[2];
    logic [127:0] rsp_data[2];
    logic [127:0] core_text[2];
    logic [127:0] core_key[2];
    logic         core_flag[2];
    logic [127:0] core_result[2];
    logic         busy[2];
`ifdef AES_ARB_STATS_EN
    logic [15:0]  stat_ops0[2];
    logic [15:0]  stat_ops1[2];
`endif

    aes_core_arbiter_if bus_a();
    aes_core_arbiter_if bus_b();

    assign bus_a.req_valid = req_valid[0];
    assign bus_a.req_text  = req_text[0];
    assign bus_a.req_key   = req_key[0];
    assign bus_a.req_mode  = req_mode[0];
    assign bus_a.rsp_ready = rsp_ready[0];
    assign req_ready[0]    = bus_a.req_ready;
    assign rsp_valid[0]    = bus_a.rsp_valid;
    assign rsp_data[0]     = bus_a.rsp_data;

    assign bus_b.req_valid = req_valid[1];
    assign bus_b.req_text  = req_text[1];
    assign bus_b.req_key   = req_key[1];
    assign bus_b.req_mode  = req_mode[1];
    assign bus_b.rsp_ready = rsp_ready[1];
    assign req_ready[1]    = bus_b.req_ready;
    assign rsp_valid[1]    = bus_b.rsp_valid;
    assign rsp_data[1]     = bus_b.rsp_data;

    aes_core_arbiter #(.SETTLE_CYCLES(SETTLE_A)) dut_a (
        .clk(clk), .rst(rst[0]), .bus(bus_a),
        .core_text(core_text[0]), .core_key(core_key[0]), .core_flag(core_flag[0]),
        .core_result(core_result[0]), .busy(busy[0])
`ifdef AES_ARB_STATS_EN
        , .stat_ops0(stat_ops0[0]), .stat_ops1(stat_ops1[0])
`endif
    );

    aes_core_arbiter #(.SETTLE_CYCLES(SETTLE_B)) dut_b (
        .clk(clk), .rst(rst[1]), .bus(bus_b),
        .core_text(core_text[1]), .core_key(core_key[1]), .core_flag(core_flag[1]),
        .core_result(core_result[1]), .busy(busy[1])
`ifdef AES_ARB_STATS_EN
        , .stat_ops0(stat_ops0[1]), .stat_ops1(stat_ops1[1])
`endif
    );

    // Stand-in for the AES datapath: exact for the FIPS-197 vector, a cheap reversible mix otherwise.
    function automatic logic [127:0] aes_stub(input logic [127:0] text, input logic [127:0] key, input logic flag);
        if (flag && key == FIPS_KEY && text == FIPS_PT) return FIPS_CT;
        if (!flag && key == FIPS_KEY && text == FIPS_CT) return FIPS_PT;
        return {text[63:0], text[127:64]} ^ key ^ {128{flag}};
    endfunction

    function automatic int settle_of(input int d);
        return (d == 0) ? SETTLE_A : SETTLE_B;
    endfunction

    // The stub returns a corrupted result until its inputs have been stable for the settle window.
    int           age[2]  = '{0, 0};
    logic [256:0] seen[2] = '{default: '0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ({core_text[d], core_key[d], core_flag[d]} !== seen[d]) begin
                seen[d] = {core_text[d], core_key[d], core_flag[d]};
                age[d]  = 0;
            end else begin
                age[d] = age[d] + 1;
            end
        end
    end
    assign core_result[0] = (age[0] >= SETTLE_A - 1) ? aes_stub(core_text[0], core_key[0], core_flag[0])
                                                    : ~aes_stub(core_text[0], core_key[0], core_flag[0]);
    assign core_result[1] = (age[1] >= SETTLE_B - 1) ? aes_stub(core_text[1], core_key[1], core_flag[1])
                                                    : ~aes_stub(core_text[1], core_key[1], core_flag[1]);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d]       = 1'b1;
        req_valid[d] = 2'b00;
        rsp_ready[d] = 2'b00;
        @(negedge clk);
        rst[d] = 1'b0;
        #1;
        check("rst_busy",      busy[d],      1'b0);
        check("rst_rsp_valid", rsp_valid[d], 2'b00);
        check("rst_req_ready", req_ready[d], 2'b00);
        check("rst_core_text", core_text[d], '0);
        check("rst_core_flag", core_flag[d], 1'b0);
        check("rst_rsp_data",  rsp_data[d],  '0);
    endtask

    // Called at the first sampling point after a handshake edge; lat counts edges until rsp_valid.
    task automatic wait_rsp(input int d, output int lat);
        lat = 0;
        while (rsp_valid[d] == 2'b00 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input int d, input logic [1:0] oh);
        @(negedge clk);
        rsp_ready[d] = oh;
        @(negedge clk);
        rsp_ready[d] = 2'b00;
        #1;
        check("ack_busy",      busy[d],      1'b0);
        check("ack_rsp_valid", rsp_valid[d], 2'b00);
    endtask

    task automatic run_vec(input int d, input vec_t v);
        logic [1:0] oh;
        int         lat;
        oh = 2'b01 << v.req;
        @(negedge clk);
        req_valid[d]                   = oh;
        req_text[d][128*v.req +: 128]  = v.text;
        req_key[d][128*v.req +: 128]   = v.key;
        req_mode[d][v.req]             = v.mode;
        rsp_ready[d]                   = 2'b00;
        #1;
        check("vec_req_ready", req_ready[d], oh);
        @(negedge clk);
        req_valid[d] = 2'b00;
        #1;
        check("vec_busy",      busy[d],      1'b1);
        check("vec_core_flag", core_flag[d], v.mode);
        check("vec_core_text", core_text[d], v.text);
        check("vec_core_key",  core_key[d],  v.key);
        wait_rsp(d, lat);
        check("vec_latency",   lat,          settle_of(d));
        check("vec_rsp_valid", rsp_valid[d], oh);
        check("vec_rsp_data",  rsp_data[d],  v.exp);
        ack(d, oh);
        check("vec_rsp_held",  rsp_data[d],  v.exp);
        check("vec_core_held", core_text[d], v.text);
    endtask

    vec_t vecs[5];

    initial begin
        int lat;
        int ngrant;
        int last;
        logic [127:0] bp_exp;

        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 2'b00;
            req_text[d]  = '0;
            req_key[d]   = '0;
            req_mode[d]  = 2'b00;
            rsp_ready[d] = 2'b00;
        end

        vecs[0] = '{req: 1'b0, text: FIPS_PT, key: FIPS_KEY, mode: 1'b1, exp: FIPS_CT};
        vecs[1] = '{req: 1'b1, text: FIPS_CT, key: FIPS_KEY, mode: 1'b0, exp: FIPS_PT};
        vecs[2] = '{req: 1'b0, text: '0, key: '0, mode: 1'b0, exp: '0};
        vecs[3] = '{req: 1'b1, text: '0, key: '0, mode: 1'b1, exp: {128{1'b1}}};
        vecs[4] = '{req: 1'b0, text: 128'h1, key: '0, mode: 1'b0,
                    exp: 128'h0000_0000_0000_0001_0000_0000_0000_0000};

        // Directed vectors: three operations by requester 0, two by requester 1.
        do_reset(0);
        for (int i = 0; i < 5; i++) run_vec(0, vecs[i]);
`ifdef AES_ARB_STATS_EN
        check("stat_ops0", stat_ops0[0], 16'd3);
        check("stat_ops1", stat_ops1[0], 16'd2);
`endif

        // Tie from reset: grants alternate starting with requester 0, one idle cycle between ops.
        do_reset(0);
        @(negedge clk);
        req_valid[0] = 2'b11;
        req_text[0]  = {128'h1111, 128'h2222};
        req_key[0]   = {128'h3333, 128'h4444};
        req_mode[0]  = 2'b01;
        rsp_ready[0] = 2'b11;
        ngrant = 0;
        last   = 0;
        for (int c = 0; c < 60 && ngrant < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready[0] != 2'b00) begin
                check("rr_grant", req_ready[0], 2'b01 << (ngrant % 2));
                if (ngrant > 0) check("rr_gap", c - last, SETTLE_A + 2);
                last = c;
                ngrant++;
            end
        end
        check("rr_count", ngrant, 4);
        @(negedge clk);
        req_valid[0] = 2'b00;

        // Backpressure on requester 1 while requester 0 waits; rsp_ready[0] must be ignored.
        do_reset(0);
        @(negedge clk);
        req_valid[0]          = 2'b10;
        req_text[0][255:128]  = 128'hfeed_0001_0002_0003_0004_0005_0006_0007;
        req_key[0][255:128]   = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        req_mode[0][1]        = 1'b1;
        bp_exp = aes_stub(128'hfeed_0001_0002_0003_0004_0005_0006_0007,
                          128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1'b1);
        #1;
        check("bp_req_ready1", req_ready[0], 2'b10);
        @(negedge clk);
        req_valid[0]        = 2'b01;
        req_text[0][127:0]  = 128'h5555_aaaa;
        req_key[0][127:0]   = 128'h7777;
        req_mode[0][0]      = 1'b0;
        #1;
        wait_rsp(0, lat);
        check("bp_latency", lat, SETTLE_A);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rsp_ready[0] = 2'b01;
            #1;
            check("bp_rsp_valid", rsp_valid[0], 2'b10);
            check("bp_rsp_data",  rsp_data[0],  bp_exp);
            check("bp_req_ready", req_ready[0], 2'b00);
        end
        @(negedge clk);
        rsp_ready[0] = 2'b10;
        @(negedge clk);
        rsp_ready[0] = 2'b00;
        #1;
        check("bp_grant_after", req_ready[0], 2'b01);
        @(negedge clk);
        req_valid[0] = 2'b00;
        #1;
        check("bp_core_text0", core_text[0], 128'h5555_aaaa);
        wait_rsp(0, lat);
        check("bp_latency0", lat, SETTLE_A);
        check("bp_rsp_data0", rsp_data[0], aes_stub(128'h5555_aaaa, 128'h7777, 1'b0));
        ack(0, 2'b01);

        // Reset one cycle after a handshake discards the operation; the next one completes normally.
        do_reset(0);
        @(negedge clk);
        req_valid[0]       = 2'b01;
        req_text[0][127:0] = 128'hbad;
        #1;
        @(negedge clk);
        req_valid[0] = 2'b00;
        rst[0]       = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        check("rst_wait_busy",      busy[0],      1'b0);
        check("rst_wait_rsp_valid", rsp_valid[0], 2'b00);
        run_vec(0, vecs[0]);

        // Settle window of one cycle on dut_b.
        do_reset(1);
        run_vec(1, vecs[0]);
        run_vec(1, vecs[1]);

        run_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Randomized traffic on dut_a checked against a transaction-level model: at most one
    // operation in flight, its response visible from SETTLE_A+1 cycles after acceptance.
    task automatic run_random();
        bit           pending[2];
        bit           inflight;
        bit           m_owner;
        bit           m_last;
        bit           win;
        int           acc;
        int           ops[2];
        logic [127:0] m_text, m_key, m_rsp;
        logic         m_mode;
        logic [1:0]   exp_ready, exp_rv;

        do_reset(0);
        pending  = '{0, 0};
        ops      = '{0, 0};
        inflight = 1'b0;
        m_last   = 1'b1;
        m_owner  = 1'b0;
        acc      = 0;
        m_text   = '0;
        m_key    = '0;
        m_mode   = 1'b0;
        m_rsp    = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i]               = 1'b1;
                    req_text[0][128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
                    req_key[0][128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
                    req_mode[0][i]           = 1'($urandom_range(0, 1));
                end else if (pending[i] && !inflight && $urandom_range(0, 7) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            req_valid[0] = {pending[1], pending[0]};
            rsp_ready[0] = 2'($urandom_range(0, 3));
            #1;

            exp_ready = 2'b00;
            win       = 1'b0;
            if (!inflight && (pending[0] || pending[1])) begin
                win       = (pending[0] && pending[1]) ? !m_last : pending[1];
                exp_ready = 2'b01 << win;
            end
            exp_rv = 2'b00;
            if (inflight && c >= acc + SETTLE_A + 1) begin
                exp_rv = 2'b01 << m_owner;
                m_rsp  = aes_stub(m_text, m_key, m_mode);
            end

            check("rnd_req_ready", req_ready[0], exp_ready);
            check("rnd_rsp_valid", rsp_valid[0], exp_rv);
            check("rnd_busy",      busy[0],      inflight);
            check("rnd_rsp_data",  rsp_data[0],  m_rsp);
            check("rnd_core_text", core_text[0], m_text);
            check("rnd_core_key",  core_key[0],  m_key);
            check("rnd_core_flag", core_flag[0], m_mode);

            if (exp_rv != 2'b00 && rsp_ready[0][m_owner]) begin
                inflight = 1'b0;
                m_last   = m_owner;
                ops[m_owner]++;
            end else if (exp_ready != 2'b00) begin
                inflight     = 1'b1;
                m_owner      = win;
                acc          = c;
                m_text       = req_text[0][128*win +: 128];
                m_key        = req_key[0][128*win +: 128];
                m_mode       = req_mode[0][win];
                pending[win] = 1'b0;
            end
        end
`ifdef AES_ARB_STATS_EN
        @(negedge clk);
        req_valid[0] = 2'b00;
        rsp_ready[0] = 2'b00;
        #1;
        check("rnd_stat_ops0", stat_ops0[0], 16'(ops[0]));
        check("rnd_stat_ops1", stat_ops1[0], 16'(ops[1]));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
